// File: rtl/wb_memory.sv
// Wishbone-style pipelined memory slave. It holds one request at a time with a programmable
// response latency, and supports byte, half-word and word lanes in little-endian order.
module wb_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_addr,
  input  logic [31:0] i_wb_data,
  input  logic [1:0]  i_data_width,
  output logic [31:0] o_wb_data,
  output logic        o_wb_ack,
  output logic        o_wb_stl
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      lane_q, lane_d;
  logic [1:0]      width_q, width_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            commit;
  logic            mem_we;
  logic [3:0]      be;
  logic [31:0]     wr_word;
  logic [31:0]     word_rd;
  logic [31:0]     rd_lane;
  logic [31:0]     mem_q [DEPTH_WORDS];

  // Upper address bits alias onto the same words.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_wb_addr[31:AW+2];

  assign word_rd = mem_q[idx_q];

  // NOTE: every output of a combinational block gets a default first; a missed branch would
  // otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    lane_d  = lane_q;
    width_d = width_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          state_d = BUSY;
          cnt_d   = LAT_M1;
          idx_d   = i_wb_addr[AW+1:2];
          lane_d  = i_wb_addr[1:0];
          width_d = i_data_width;
          we_d    = i_wb_we;
          wdata_d = i_wb_data;
        end
      end
      BUSY: begin
        // A dropped cycle abandons the request, even on the edge that would have acked it.
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = ACK;
          ack_d   = 1'b1;
          commit  = 1'b1;
          if (!we_q) rdata_d = rd_lane;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    be      = 4'b0000;
    wr_word = 32'h0;
    rd_lane = 32'h0;
    unique case (width_q)
      2'b00: begin
        be      = 4'b0001 << lane_q;
        wr_word = {4{wdata_q[7:0]}};
        rd_lane = {24'h0, word_rd[{lane_q, 3'b000} +: 8]};
      end
      2'b01: begin
        be      = lane_q[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wdata_q[15:0]}};
        rd_lane = lane_q[1] ? {16'h0, word_rd[31:16]} : {16'h0, word_rd[15:0]};
      end
      2'b10: begin
        be      = 4'b1111;
        wr_word = wdata_q;
        rd_lane = word_rd;
      end
      default: begin
        be      = 4'b0000;
        wr_word = 32'h0;
        rd_lane = 32'h0;
      end
    endcase
  end

  assign mem_we = commit && we_q && !reset;

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q   <= idx_d;
    lane_q  <= lane_d;
    width_q <= width_d;
    we_q    <= we_d;
    wdata_q <= wdata_d;
  end

  // NOTE: the storage array has no reset; reset must leave its contents intact, and a reset
  // network over every word would only add cost.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx_q][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

  assign o_wb_data = rdata_q;
  assign o_wb_ack  = ack_q;
  assign o_wb_stl  = (state_q != IDLE);

endmodule

// File: doc/wb_memory.md
WB_MEMORY -- requirements
Module: wb_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 16..4096).
REQ-002 Parameter LATENCY, default 1, clock edges from request acceptance to o_wb_ack (1..15).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 i_wb_cyc  input  1  bus cycle in progress from the master.
REQ-006 i_wb_stb  input  1  request strobe.
REQ-007 i_wb_we  input  1  1 = write, 0 = read.
REQ-008 i_wb_addr  input  32  byte address.
REQ-009 i_wb_data  input  32  write data, value right-aligned in low bits for byte/half.
REQ-010 i_data_width  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-011 o_wb_data  output  32  read data, right-aligned, zero-extended.
REQ-012 o_wb_ack  output  1  one-cycle completion pulse.
REQ-013 o_wb_stl  output  1  stall; request not accepted while high.

Function
REQ-014 FSM states IDLE, BUSY, ACK; o_wb_stl = (state != IDLE), derived from registered state only.
REQ-015 Acceptance: rising edge where state = IDLE and i_wb_cyc & i_wb_stb; capture addr, data, we, width; go to BUSY with latency counter = LATENCY-1.
REQ-016 BUSY: counter decrements each edge; at 0 go to ACK (LATENCY=1: ACK on the edge after acceptance, i.e. o_wb_ack high exactly 1 cycle after the accepting edge... by REQ-017 below).
REQ-017 o_wb_ack is registered, high for exactly one cycle, LATENCY cycles after the accepting edge; state returns to IDLE on the next edge.
REQ-018 At most one outstanding request; back-to-back requests accepted no sooner than the cycle after o_wb_ack.
REQ-019 Word index = captured addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored (aliasing wrap-around).
REQ-020 Little-endian lanes: byte uses addr[1:0]; half uses addr[1] (addr[0] ignored); word ignores addr[1:0].
REQ-021 Write commits on the edge that raises o_wb_ack; only selected lanes change, other lanes keep old contents.
REQ-022 Read samples memory on the edge that raises o_wb_ack; o_wb_data = selected lane(s) zero-extended to 32 bits.
REQ-023 o_wb_data holds its value when o_wb_ack is low; it changes only on an acked read.
REQ-024 Width 11: request acked normally, no memory write, read returns 0x00000000.
REQ-025 Abort: i_wb_cyc low on any edge in BUSY -> IDLE next edge, no write, no ack, o_wb_data unchanged.
REQ-026 i_wb_stb high while stalled is ignored; no request queued.
REQ-027 i_wb_we/i_wb_data/i_wb_addr changes after acceptance have no effect on the in-flight request.

Reset
REQ-028 reset high on an edge: state IDLE, o_wb_ack 0, o_wb_stl 0, o_wb_data 0x00000000, counter 0; overrides every other event that edge.
REQ-029 Reset during BUSY or ACK drops the request: no write commits, no ack issued.
REQ-030 Memory contents are not cleared by reset; power-up contents undefined except where loaded by simulation initialisation.

Verification
REQ-031 LATENCY=1: write word 0xDEADBEEF @0x10, then read word @0x10 -> ack 1 cycle after each accept, o_wb_data 0xDEADBEEF, o_wb_stl high only during BUSY/ACK.
REQ-032 Lane writes: word 0x00000000 @0x20, byte 0xAB @0x23, half 0x1234 @0x20 -> word read @0x20 returns 0xAB001234; byte read @0x23 returns 0x000000AB.
REQ-033 LATENCY=3: read accepted at cycle N -> o_wb_ack high only at cycle N+3; stb held high during stall produces no second ack.
REQ-034 Abort: write 0x55555555 @0x40 accepted, cyc dropped next cycle -> no ack, subsequent word read @0x40 returns previous contents.
REQ-035 Reset asserted in BUSY -> next cycle o_wb_stl 0, o_wb_ack 0, o_wb_data 0; pending write absent on readback.
REQ-036 Alias/reserved: DEPTH_WORDS=256, write word 0x11223344 @0x400 -> read @0x000 returns 0x11223344; width 11 read returns 0x00000000 with one ack.
